// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bank between requesters.
// Owners are separated by an all-input turnaround so pad drivers never overlap.
module uio_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   dir,
    input  logic [8*N_REQ-1:0] wdata,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    output logic [N_REQ-1:0]   gnt,
    output logic [7:0]         rdata,
    output logic               rvalid,
    output logic               busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 2);
    localparam int TW = $clog2(TURN_CYC + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last_owner;
    logic [IW-1:0] pick;
    logic          pick_ok;
    logic          owner_dir;
    logic          release_now;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] turn_cnt;

    // Lowest offset from last_owner wins; the loop runs high to low so it overwrites last.
    always_comb begin : rr_pick
        logic [IW:0] idx;
        idx     = '0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = {1'b0, last_owner} + (IW+1)'(k);
            if (idx >= (IW+1)'(N_REQ)) begin
                idx = idx - (IW+1)'(N_REQ);
            end
            if (req[idx[IW-1:0]]) begin
                pick    = idx[IW-1:0];
                pick_ok = 1'b1;
            end
        end
    end

    assign release_now = !req[owner] || !ena ||
                         ((MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD)));

    assign busy = (state != S_IDLE);

    always_comb begin
        uio_out = 8'h00;
        if (state == S_GRANT && owner_dir) begin
            uio_out = wdata[{owner, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_owner <= IW'(N_REQ - 1);
            owner_dir  <= 1'b0;
            hold_cnt   <= '0;
            turn_cnt   <= '0;
            gnt        <= '0;
            uio_oe     <= 8'h00;
            rdata      <= 8'h00;
            rvalid     <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (ena && pick_ok) begin
                        state      <= S_GRANT;
                        owner      <= pick;
                        last_owner <= pick;
                        owner_dir  <= dir[pick];
                        gnt        <= N_REQ'(1) << pick;
                        hold_cnt   <= HW'(1);
                        uio_oe     <= {8{dir[pick]}};
                    end
                end
                (state == S_GRANT): begin
                    if (!owner_dir) begin
                        rdata  <= uio_in;
                        rvalid <= 1'b1;
                    end
                    if (release_now) begin
                        state    <= S_TURN;
                        gnt      <= '0;
                        uio_oe   <= 8'h00;
                        turn_cnt <= TW'(1);
                    end else if (MAX_HOLD != 0) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                (state == S_TURN): begin
                    if (turn_cnt == TW'(TURN_CYC)) begin
                        state <= S_IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    gnt    <= '0;
                    uio_oe <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter with grant and read-data scoreboards.
module tb_uio_bus_arbiter;

    localparam int N  = 4;
    localparam int TC = 1;
    localparam int MH = 16;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena   = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   dir   = '0;
    logic [8*N-1:0] wdata = '0;
    logic [7:0]     uio_in = 8'h00;
    logic [7:0]     uio_out;
    logic [7:0]     uio_oe;
    logic [N-1:0]   gnt;
    logic [7:0]     rdata;
    logic           rvalid;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rq[$];
    int         gq[$];

    uio_bus_arbiter #(
        .N_REQ(N),
        .TURN_CYC(TC),
        .MAX_HOLD(MH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .req(req),
        .dir(dir),
        .wdata(wdata),
        .uio_in(uio_in),
        .uio_out(uio_out),
        .uio_oe(uio_oe),
        .gnt(gnt),
        .rdata(rdata),
        .rvalid(rvalid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [N-1:0] gprev = '0;
    int           gap   = 0;
    bit           had   = 1'b0;

    // Monitor: invariants, grant-order and read-data scoreboards.
    always @(negedge clk) begin
        if (!rst_n) begin
            had   = 1'b0;
            gap   = 0;
            gprev = '0;
        end else begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
            chk("oe_legal", 32'(uio_oe == 8'h00 || uio_oe == 8'hFF), 1);
            if (uio_oe == 8'hFF) chk("oe_needs_gnt", 32'(gnt != '0), 1);
            if (rvalid) begin
                if (rq.size() == 0) chk("rvalid_spurious", 32'(rvalid), 0);
                else chk("rdata", rdata, rq.pop_front());
            end
            if (gnt != '0 && gprev == '0) begin
                if (had) chk("turn_gap", 32'(gap >= TC + 1), 1);
                if (gq.size() == 0) chk("gnt_spurious", gnt, 0);
                else chk("gnt_owner", gnt, 32'(1) << gq.pop_front());
                gap = 0;
            end
            if (gnt == '0) gap++;
            else had = 1'b1;
            gprev = gnt;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int ord[5];
        ord = '{2, 3, 0, 1, 2};

        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_oe", uio_oe, 0);
        chk("rst_out", uio_out, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_busy", busy, 0);
        #2 rst_n = 1'b1;
        ena = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_gnt", gnt, 0);
            chk("idle_busy", busy, 0);
            chk("idle_oe", uio_oe, 0);
        end

        // single write, dir change mid-grant ignored
        req = 4'b0001; dir = 4'b0001; wdata[7:0] = 8'hA5;
        gq.push_back(0);
        @(negedge clk);
        chk("wr_gnt", gnt, 4'b0001);
        chk("wr_oe", uio_oe, 8'hFF);
        chk("wr_out", uio_out, 8'hA5);
        chk("wr_busy", busy, 1);
        dir = 4'b0000; wdata[7:0] = 8'h5A;
        @(negedge clk);
        chk("wr_dirlatch_oe", uio_oe, 8'hFF);
        chk("wr_out_live", uio_out, 8'h5A);
        req = '0;
        @(negedge clk);
        chk("rel_gnt", gnt, 0);
        chk("rel_oe", uio_oe, 0);
        chk("rel_out", uio_out, 0);
        chk("turn_busy", busy, 1);
        @(negedge clk);
        chk("idle_after_turn", busy, 0);

        // read burst
        req = 4'b0010; dir = 4'b0000;
        gq.push_back(1);
        @(negedge clk);
        chk("rd_gnt", gnt, 4'b0010);
        chk("rd_oe", uio_oe, 0);
        chk("rd_out", uio_out, 0);
        uio_in = 8'h3C; rq.push_back(8'h3C);
        @(negedge clk);
        uio_in = 8'h3D; rq.push_back(8'h3D);
        @(negedge clk);
        uio_in = 8'h3E; rq.push_back(8'h3E);
        req = '0;
        @(negedge clk);
        chk("rd_rel_gnt", gnt, 0);
        chk("rd_last_rvalid", rvalid, 1);
        uio_in = 8'hEE;
        @(negedge clk);
        chk("rd_turn_norvalid", rvalid, 0);
        chk("rd_rdata_hold", rdata, 8'h3E);
        chk("rd_idle_busy", busy, 0);

        // round robin with all requesters, last_owner=1
        dir = 4'b1111;
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        for (int g = 0; g < 5; g++) gq.push_back(ord[g]);
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (gnt == '0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("rr_wait", n, (g == 0) ? 1 : TC + 1);
            chk("rr_gnt", gnt, 32'(1) << ord[g]);
            chk("rr_out", uio_out, 8'h10 + ord[g]);
            len = 0;
            while (gnt != '0 && len < 40) begin
                @(negedge clk);
                len++;
            end
            chk("rr_hold", len, MH);
        end
        req = '0;
        @(negedge clk);
        chk("rr_idle", busy, 0);

        // ena drop mid-grant, then resume with last_owner=2
        req = 4'b0100; dir = 4'b0100; wdata[23:16] = 8'hC3;
        gq.push_back(2);
        @(negedge clk);
        chk("ena_gnt", gnt, 4'b0100);
        chk("ena_out", uio_out, 8'hC3);
        ena = 1'b0;
        @(negedge clk);
        chk("ena_rel_gnt", gnt, 0);
        chk("ena_rel_oe", uio_oe, 0);
        repeat (4) begin
            @(negedge clk);
            chk("ena_block", gnt, 0);
        end
        chk("ena_idle_busy", busy, 0);
        req = 4'b0101; dir = 4'b0101; wdata[7:0] = 8'h66; ena = 1'b1;
        gq.push_back(0);
        @(negedge clk);
        chk("ena_rr_gnt", gnt, 4'b0001);
        chk("ena_rr_oe", uio_oe, 8'hFF);
        chk("ena_rr_out", uio_out, 8'h66);

        // asynchronous reset mid-write
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", uio_oe, 0);
        chk("arst_gnt", gnt, 0);
        chk("arst_out", uio_out, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        gq.push_back(0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_idle", busy, 0);

        // sole hog, forced release and re-grant
        req = 4'b0100; dir = 4'b0100;
        gq.push_back(2);
        gq.push_back(2);
        n = 0;
        while (gnt == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hog_wait", n, 1);
        len = 0;
        while (gnt != '0 && len < 40) begin
            @(negedge clk);
            len++;
        end
        chk("hog_hold", len, MH);
        n = 0;
        while (gnt == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hog_regrant_gap", n, TC + 1);
        chk("hog_regrant", gnt, 4'b0100);
        req = '0;
        @(negedge clk);
        chk("hog_rel", gnt, 0);
        @(negedge clk);
        chk("hog_idle", busy, 0);

        repeat (2) @(negedge clk);
        chk("gq_drained", gq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
